pipeline_hazard_controller: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline. It tracks in-flight register writes behind the ID stage and drives the pipeline enables: PC load enable, IF/ID load enable, and ID/EX bubble insertion. It also drives operand-A/B forwarding selects, and runs a multi-cycle counter for mult/div so that HI/LO readers are held until results exist. It sits beside the ID stage, between the control unit and the IF/ID and ID/EX pipeline registers.

---
 rtl/pipeline_hazard_controller.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller beside the ID stage: scoreboard of in-flight writes,
// forwarding selects, load-use and HI/LO stalls, and the mult/div occupancy counter.
module pipeline_hazard_controller #(
  parameter int MD_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_USES_RS,
  input  logic        ID_USES_RT,
  input  logic [4:0]  ID_DEST,
  input  logic        ID_RF_ENABLE,
  input  logic        ID_LOAD_INSTR,
  input  logic        ID_MD_START,
  input  logic        ID_HILO_READ,
  output logic        PC_LE,
  output logic        IF_ID_LE,
  output logic        ID_EX_NOP,
  output logic [1:0]  FWD_A_SEL,
  output logic [1:0]  FWD_B_SEL,
  output logic        MD_BUSY,
  output logic [15:0] STALL_COUNT
);

  localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY);

  typedef struct packed {
    logic [4:0] dest;
    logic       rfen;
    logic       load;
  } sb_entry_t;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_t;

  sb_entry_t ex_p0, mem_p1, wb_p2;
  md_state_t md_state, md_state_next;
  logic [3:0] md_cnt, md_cnt_next;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;
  logic load_use, hilo_hazard, stall;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic hit(sb_entry_t e, logic [4:0] src, logic uses);
    return e.rfen && (e.dest != 5'd0) && (e.dest == src) && uses;
  endfunction

  function automatic logic [1:0] fwd_sel(logic h_ex, logic h_mem, logic h_wb);
    if (h_ex)       return 2'b01;
    else if (h_mem) return 2'b10;
    else if (h_wb)  return 2'b11;
    else            return 2'b00;
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage ID: hazard detection against the scoreboard
  always_comb begin
    ex_rs_hit  = hit(ex_p0,  ID_RS, ID_USES_RS);
    ex_rt_hit  = hit(ex_p0,  ID_RT, ID_USES_RT);
    mem_rs_hit = hit(mem_p1, ID_RS, ID_USES_RS);
    mem_rt_hit = hit(mem_p1, ID_RT, ID_USES_RT);
    wb_rs_hit  = hit(wb_p2,  ID_RS, ID_USES_RS);
    wb_rt_hit  = hit(wb_p2,  ID_RT, ID_USES_RT);
    fwd_a       = fwd_sel(ex_rs_hit, mem_rs_hit, wb_rs_hit);
    fwd_b       = fwd_sel(ex_rt_hit, mem_rt_hit, wb_rt_hit);
    load_use    = ex_p0.load && (ex_rs_hit || ex_rt_hit);
    hilo_hazard = (md_state == MD_RUN) && (ID_HILO_READ || ID_MD_START);
    stall       = load_use || hilo_hazard;
  end

  // Reset low holds the pipeline frozen with a bubble regardless of state
  assign PC_LE     = Reset && !stall;
  assign IF_ID_LE  = Reset && !stall;
  assign ID_EX_NOP = !Reset || stall;
  assign FWD_A_SEL = Reset ? fwd_a : 2'b00;
  assign FWD_B_SEL = Reset ? fwd_b : 2'b00;
  assign MD_BUSY   = (md_state == MD_RUN);

  always_comb begin
    md_state_next = md_state;
    md_cnt_next   = md_cnt;
    case (md_state)
      MD_IDLE: begin
        if (ID_MD_START && !stall) begin
          md_state_next = MD_RUN;
          md_cnt_next   = MD_CNT_INIT;
        end
      end
      MD_RUN: begin
        md_cnt_next = md_cnt - 4'd1;
        if (md_cnt == 4'd1) md_state_next = MD_IDLE;
      end
      default: md_state_next = MD_IDLE;
    endcase
  end

  // Stage EX/MEM/WB: scoreboard shift, bubble enters EX on stall
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_p0  <= '0;
      mem_p1 <= '0;
      wb_p2  <= '0;
    end else begin
      wb_p2  <= mem_p1;
      mem_p1 <= ex_p0;
      ex_p0  <= stall ? '0 : {ID_DEST, ID_RF_ENABLE, ID_LOAD_INSTR};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      md_state    <= MD_IDLE;
      md_cnt      <= 4'd0;
      STALL_COUNT <= 16'd0;
    end else begin
      md_state <= md_state_next;
      md_cnt   <= md_cnt_next;
      if (stall) STALL_COUNT <= sat_inc(STALL_COUNT);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// stimulus compared every cycle against a history-based reference model.
module tb_pipeline_hazard_controller;
  localparam int MD_LAT = 4;

  logic        Clk, Reset;
  logic [4:0]  ID_RS, ID_RT, ID_DEST;
  logic        ID_USES_RS, ID_USES_RT, ID_RF_ENABLE, ID_LOAD_INSTR;
  logic        ID_MD_START, ID_HILO_READ;
  logic        PC_LE, IF_ID_LE, ID_EX_NOP, MD_BUSY;
  logic [1:0]  FWD_A_SEL, FWD_B_SEL;
  logic [15:0] STALL_COUNT;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_controller #(.MD_LATENCY(MD_LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT),
    .ID_DEST(ID_DEST), .ID_RF_ENABLE(ID_RF_ENABLE),
    .ID_LOAD_INSTR(ID_LOAD_INSTR), .ID_MD_START(ID_MD_START),
    .ID_HILO_READ(ID_HILO_READ),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .ID_EX_NOP(ID_EX_NOP),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .MD_BUSY(MD_BUSY), .STALL_COUNT(STALL_COUNT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: what was issued 1, 2 and 3 cycles ago, mult/div cycles left
  typedef struct {
    logic [4:0] dest;
    logic       rfen;
    logic       load;
  } ent_t;

  ent_t age[3];
  int   md_left;
  int   stall_total;

  task automatic model_clear();
    for (int k = 0; k < 3; k++) age[k] = '{dest: 5'd0, rfen: 1'b0, load: 1'b0};
    md_left     = 0;
    stall_total = 0;
  endtask

  function automatic int fwd_exp(logic [4:0] s, logic u);
    for (int k = 0; k < 3; k++)
      if (u && age[k].rfen && age[k].dest != 5'd0 && age[k].dest == s) return k + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lu, hl;
    lu = age[0].load && age[0].rfen && age[0].dest != 5'd0 &&
         ((ID_USES_RS && age[0].dest == ID_RS) || (ID_USES_RT && age[0].dest == ID_RT));
    hl = (md_left > 0) && (ID_HILO_READ || ID_MD_START);
    return lu || hl;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      model_clear();
    end else begin
      bit st;
      st = exp_stall();
      age[2] = age[1];
      age[1] = age[0];
      if (st) age[0] = '{dest: 5'd0, rfen: 1'b0, load: 1'b0};
      else    age[0] = '{dest: ID_DEST, rfen: ID_RF_ENABLE, load: ID_LOAD_INSTR};
      if (md_left > 0) md_left = md_left - 1;
      else if (ID_MD_START && !st) md_left = MD_LAT;
      if (st && stall_total < 65535) stall_total = stall_total + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    bit e_st;
    int fa, fb;
    if (!Reset) begin
      chk("rst_pc_le", {15'd0, PC_LE}, 16'd0);
      chk("rst_if_id_le", {15'd0, IF_ID_LE}, 16'd0);
      chk("rst_nop", {15'd0, ID_EX_NOP}, 16'd1);
      chk("rst_fwd_a", {14'd0, FWD_A_SEL}, 16'd0);
      chk("rst_fwd_b", {14'd0, FWD_B_SEL}, 16'd0);
      chk("rst_md_busy", {15'd0, MD_BUSY}, 16'd0);
      chk("rst_stall_count", STALL_COUNT, 16'd0);
    end else begin
      e_st = exp_stall();
      fa = fwd_exp(ID_RS, ID_USES_RS);
      fb = fwd_exp(ID_RT, ID_USES_RT);
      chk("m_pc_le", {15'd0, PC_LE}, {15'd0, !e_st});
      chk("m_if_id_le", {15'd0, IF_ID_LE}, {15'd0, !e_st});
      chk("m_nop", {15'd0, ID_EX_NOP}, {15'd0, e_st});
      chk("m_fwd_a", {14'd0, FWD_A_SEL}, 16'(fa));
      chk("m_fwd_b", {14'd0, FWD_B_SEL}, 16'(fb));
      chk("m_md_busy", {15'd0, MD_BUSY}, {15'd0, md_left > 0});
      chk("m_stall_count", STALL_COUNT, 16'(stall_total));
    end
  end

  task automatic idle();
    ID_RS = 5'd0; ID_RT = 5'd0; ID_DEST = 5'd0;
    ID_USES_RS = 1'b0; ID_USES_RT = 1'b0; ID_RF_ENABLE = 1'b0;
    ID_LOAD_INSTR = 1'b0; ID_MD_START = 1'b0; ID_HILO_READ = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic flush(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      idle();
    end
  endtask

  task automatic issue_add5();
    idle();
    ID_DEST = 5'd5; ID_RF_ENABLE = 1'b1;
  endtask

  task automatic read_rs5();
    idle();
    ID_RS = 5'd5; ID_USES_RS = 1'b1;
  endtask

  initial begin
    model_clear();
    idle();
    Reset = 1'b0;
    #2;
    chk("reset_pc_le", {15'd0, PC_LE}, 16'd0);
    chk("reset_nop", {15'd0, ID_EX_NOP}, 16'd1);
    chk("reset_md_busy", {15'd0, MD_BUSY}, 16'd0);
    chk("reset_stall_count", STALL_COUNT, 16'd0);
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    chk("idle_pc_le", {15'd0, PC_LE}, 16'd1);
    chk("idle_if_id_le", {15'd0, IF_ID_LE}, 16'd1);
    chk("idle_nop", {15'd0, ID_EX_NOP}, 16'd0);
    chk("idle_fwd_a", {14'd0, FWD_A_SEL}, 16'd0);
    chk("idle_stall_count", STALL_COUNT, 16'd0);

    // Forwarding distance 1, 2, 3
    step(); issue_add5();
    step(); read_rs5(); #1 chk("fwd_ex", {14'd0, FWD_A_SEL}, 16'd1);
    flush(3);
    step(); issue_add5();
    step(); idle();
    step(); read_rs5(); #1 chk("fwd_mem", {14'd0, FWD_A_SEL}, 16'd2);
    flush(3);
    step(); issue_add5();
    step(); idle();
    step(); idle();
    step(); read_rs5(); #1 chk("fwd_wb", {14'd0, FWD_A_SEL}, 16'd3);
    flush(3);

    // Load-use: one bubble, then MEM forward
    step(); idle(); ID_DEST = 5'd8; ID_RF_ENABLE = 1'b1; ID_LOAD_INSTR = 1'b1;
    step(); idle(); ID_RT = 5'd8; ID_USES_RT = 1'b1;
    #1;
    chk("lu_pc_le", {15'd0, PC_LE}, 16'd0);
    chk("lu_if_id_le", {15'd0, IF_ID_LE}, 16'd0);
    chk("lu_nop", {15'd0, ID_EX_NOP}, 16'd1);
    step(); #1;
    chk("lu_after_pc_le", {15'd0, PC_LE}, 16'd1);
    chk("lu_after_fwd_b", {14'd0, FWD_B_SEL}, 16'd2);
    chk("lu_stall_count", STALL_COUNT, 16'd1);
    flush(3);

    // Register $0 never forwards or stalls
    step(); idle(); ID_DEST = 5'd0; ID_RF_ENABLE = 1'b1; ID_LOAD_INSTR = 1'b1;
    step(); idle(); ID_USES_RS = 1'b1; ID_USES_RT = 1'b1;
    #1;
    chk("r0_fwd_a", {14'd0, FWD_A_SEL}, 16'd0);
    chk("r0_fwd_b", {14'd0, FWD_B_SEL}, 16'd0);
    chk("r0_pc_le", {15'd0, PC_LE}, 16'd1);
    flush(3);

    // mult then mfhi: four stall cycles
    step(); idle(); ID_MD_START = 1'b1;
    step(); idle(); ID_HILO_READ = 1'b1;
    for (int k = 0; k < MD_LAT; k++) begin
      #1;
      chk("md_busy_hold", {15'd0, MD_BUSY}, 16'd1);
      chk("md_pc_le_hold", {15'd0, PC_LE}, 16'd0);
      step();
    end
    #1;
    chk("md_release_busy", {15'd0, MD_BUSY}, 16'd0);
    chk("md_release_pc_le", {15'd0, PC_LE}, 16'd1);
    chk("md_stall_count", STALL_COUNT, 16'd5);
    flush(2);

    // Random traffic with one reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      step();
      ID_RS         = 5'($urandom_range(0, 7));
      ID_RT         = 5'($urandom_range(0, 7));
      ID_DEST       = 5'($urandom_range(0, 7));
      ID_USES_RS    = ($urandom_range(0, 3) != 0);
      ID_USES_RT    = ($urandom_range(0, 3) != 0);
      ID_RF_ENABLE  = ($urandom_range(0, 3) != 0);
      ID_LOAD_INSTR = ID_RF_ENABLE && ($urandom_range(0, 2) == 0);
      ID_MD_START   = ($urandom_range(0, 9) == 0);
      ID_HILO_READ  = ($urandom_range(0, 5) == 0);
      if (i == 1500) #2 Reset = 1'b0;
      if (i == 1503) #2 Reset = 1'b1;
    end
    flush(6);

    // Asynchronous reset during an active mult/div
    step(); idle(); ID_MD_START = 1'b1; ID_DEST = 5'd5; ID_RF_ENABLE = 1'b1;
    step(); read_rs5();
    #1;
    chk("pre_rst_busy", {15'd0, MD_BUSY}, 16'd1);
    chk("pre_rst_fwd_a", {14'd0, FWD_A_SEL}, 16'd1);
    #2 Reset = 1'b0;
    #1;
    chk("arst_md_busy", {15'd0, MD_BUSY}, 16'd0);
    chk("arst_pc_le", {15'd0, PC_LE}, 16'd0);
    chk("arst_if_id_le", {15'd0, IF_ID_LE}, 16'd0);
    chk("arst_nop", {15'd0, ID_EX_NOP}, 16'd1);
    chk("arst_fwd_a", {14'd0, FWD_A_SEL}, 16'd0);
    chk("arst_stall_count", STALL_COUNT, 16'd0);
    step();
    step();
    #2 Reset = 1'b1;
    idle();
    step();
    step();
    #1;
    chk("post_rst_busy", {15'd0, MD_BUSY}, 16'd0);
    chk("post_rst_fwd_a", {14'd0, FWD_A_SEL}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
